// File: rtl/reg_status_table_pkg.sv
// ----------------------------------------------------------------------------
// reg_status_table_pkg
// Shared defaults for the register status table and its per-register entry.
// Holds the width defaults, the "no pending producer" tag value and the
// helper that locates one port's field inside a packed multi-port bus.
// Optional feature macro used by the top level: CDB_BYPASS_EN.
// ----------------------------------------------------------------------------
package reg_status_table_pkg;

    localparam int DEF_REG_INDEX = 5;   // register number width, depth = 2**REG_INDEX
    localparam int DEF_WORD_SIZE = 32;  // register value width
    localparam int DEF_FU_INDEX  = 3;   // producer tag width
    localparam int DEF_READY     = 0;   // tag meaning "value valid, no producer"
    localparam int DEF_NUM_READ  = 3;   // operand lookup ports
    localparam int DEF_NUM_ISSUE = 2;   // rename write ports

    // Lowest bit of port `port` inside a packed bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_status_table_entry.sv
// ----------------------------------------------------------------------------
// reg_status_table_entry
// One architectural register: its value and the tag of the functional unit
// that will produce its next value. Computes next state from the CDB
// broadcast, the already-resolved rename for this register, and flush.
// State changes on the falling clock edge.
//
// Ports:
//   clk          in   clock (state updates on negedge)
//   reset        in   asynchronous active-high reset
//   i_cdb_valid  in   CDB broadcast valid
//   i_cdb_tag    in   broadcasting FU tag
//   i_cdb_data   in   broadcast result
//   i_flush      in   clear tag to READY, keep value
//   i_ren_en     in   this register is renamed on this edge
//   i_ren_tag    in   new producer tag for the rename
//   o_value      out  stored value
//   o_tag        out  stored producer tag
//   o_tag_next   out  tag after the coming edge (feeds the pending counter)
// ----------------------------------------------------------------------------
module reg_status_table_entry
    import reg_status_table_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int FU_INDEX  = DEF_FU_INDEX,
    parameter int READY     = DEF_READY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_cdb_valid,
    input  logic [FU_INDEX-1:0]  i_cdb_tag,
    input  logic [WORD_SIZE-1:0] i_cdb_data,
    input  logic                 i_flush,
    input  logic                 i_ren_en,
    input  logic [FU_INDEX-1:0]  i_ren_tag,
    output logic [WORD_SIZE-1:0] o_value,
    output logic [FU_INDEX-1:0]  o_tag,
    output logic [FU_INDEX-1:0]  o_tag_next
);

    localparam logic [FU_INDEX-1:0] READY_TAG = FU_INDEX'(READY);

    logic [WORD_SIZE-1:0] r_value;
    logic [FU_INDEX-1:0]  r_tag;
    logic                 w_cdb_hit;
    logic [WORD_SIZE-1:0] w_value_next;
    logic [FU_INDEX-1:0]  w_tag_next;

    // A broadcast of the READY tag never matches: READY means "no producer".
    assign w_cdb_hit = i_cdb_valid && (i_cdb_tag != READY_TAG) && (r_tag == i_cdb_tag);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        w_value_next = r_value;
        w_tag_next   = r_tag;
        if (w_cdb_hit) begin
            w_value_next = i_cdb_data;
            w_tag_next   = READY_TAG;
        end
        // Rename overrides the broadcast on status; the value still lands.
        if (i_ren_en) begin
            w_tag_next = i_ren_tag;
        end
        // Flush overrides renames on status only.
        if (i_flush) begin
            w_tag_next = READY_TAG;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: values are architecturally visible right after reset,
            // so they are reset here, not just the tags.
            r_value <= '0;
            r_tag   <= READY_TAG;
        end else begin
            // NOTE: non-blocking so all entries sample pre-edge state together.
            r_value <= w_value_next;
            r_tag   <= w_tag_next;
        end
    end

    assign o_value    = r_value;
    assign o_tag      = r_tag;
    assign o_tag_next = w_tag_next;

endmodule

// File: rtl/reg_status_table.sv
// ----------------------------------------------------------------------------
// reg_status_table
// Register status table for the Tomasulo core: architectural values plus a
// per-register producer tag. Accepts NUM_ISSUE renames and one CDB broadcast
// per cycle, offers NUM_READ combinational lookups, a synchronous flush of
// all tags and a registered count of pending registers. State changes on
// the falling clock edge.
//
// Optional feature macro: CDB_BYPASS_EN -- when defined, a lookup whose
// stored tag matches the current CDB broadcast returns the broadcast data
// and READY status in the same cycle.
//
// Ports:
//   clk            in   clock (state updates on negedge)
//   reset          in   asynchronous active-high reset
//   rd_num         in   packed lookup register numbers, port k at [k*REG_INDEX +: REG_INDEX]
//   rd_value       out  packed looked-up values
//   rd_status      out  packed looked-up producer tags
//   iss_en         in   rename write enables, higher index = later in program order
//   iss_reg        in   packed rename destination registers
//   iss_tag        in   packed new producer tags (never READY when enabled)
//   cdb_valid      in   CDB broadcast valid
//   cdb_tag        in   broadcasting FU tag
//   cdb_data       in   broadcast result
//   flush          in   clear all tags to READY, values kept
//   pending_count  out  number of registers whose tag is not READY
// ----------------------------------------------------------------------------
module reg_status_table
    import reg_status_table_pkg::*;
#(
    parameter int REG_INDEX = DEF_REG_INDEX,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int FU_INDEX  = DEF_FU_INDEX,
    parameter int READY     = DEF_READY,
    parameter int NUM_READ  = DEF_NUM_READ,
    parameter int NUM_ISSUE = DEF_NUM_ISSUE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_READ*REG_INDEX-1:0] rd_num,
    output logic [NUM_READ*WORD_SIZE-1:0] rd_value,
    output logic [NUM_READ*FU_INDEX-1:0]  rd_status,
    input  logic [NUM_ISSUE-1:0]          iss_en,
    input  logic [NUM_ISSUE*REG_INDEX-1:0] iss_reg,
    input  logic [NUM_ISSUE*FU_INDEX-1:0] iss_tag,
    input  logic                          cdb_valid,
    input  logic [FU_INDEX-1:0]           cdb_tag,
    input  logic [WORD_SIZE-1:0]          cdb_data,
    input  logic                          flush,
    output logic [REG_INDEX:0]            pending_count
);

    localparam int                  DEPTH     = 2 ** REG_INDEX;
    localparam logic [FU_INDEX-1:0] READY_TAG = FU_INDEX'(READY);

    logic                 w_ren_en   [DEPTH];
    logic [FU_INDEX-1:0]  w_ren_tag  [DEPTH];
    logic [WORD_SIZE-1:0] w_value    [DEPTH];
    logic [FU_INDEX-1:0]  w_tag      [DEPTH];
    logic [FU_INDEX-1:0]  w_tag_next [DEPTH];
    logic [REG_INDEX:0]   w_pending_next;
    logic [REG_INDEX:0]   r_pending_count;

    // Rename decode: ports are scanned in program order, so a later port
    // writing the same register overwrites an earlier one.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            w_ren_en[r]  = 1'b0;
            w_ren_tag[r] = READY_TAG;
        end
        for (int p = 0; p < NUM_ISSUE; p++) begin
            if (iss_en[p]) begin
                w_ren_en[iss_reg[slice_lo(p, REG_INDEX) +: REG_INDEX]]  = 1'b1;
                w_ren_tag[iss_reg[slice_lo(p, REG_INDEX) +: REG_INDEX]] =
                    iss_tag[slice_lo(p, FU_INDEX) +: FU_INDEX];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        reg_status_table_entry #(
            .WORD_SIZE (WORD_SIZE),
            .FU_INDEX  (FU_INDEX),
            .READY     (READY)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .i_cdb_valid (cdb_valid),
            .i_cdb_tag   (cdb_tag),
            .i_cdb_data  (cdb_data),
            .i_flush     (flush),
            .i_ren_en    (w_ren_en[g]),
            .i_ren_tag   (w_ren_tag[g]),
            .o_value     (w_value[g]),
            .o_tag       (w_tag[g]),
            .o_tag_next  (w_tag_next[g])
        );
    end

    // Read muxes: reads see stored state, so a same-cycle rename is not
    // visible until after the edge.
    always_comb begin
        logic [REG_INDEX-1:0] w_idx;
        rd_value  = '0;
        rd_status = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            w_idx = rd_num[slice_lo(k, REG_INDEX) +: REG_INDEX];
            rd_value[slice_lo(k, WORD_SIZE) +: WORD_SIZE] = w_value[w_idx];
            rd_status[slice_lo(k, FU_INDEX) +: FU_INDEX]  = w_tag[w_idx];
`ifdef CDB_BYPASS_EN
            if (cdb_valid && (cdb_tag != READY_TAG) && (w_tag[w_idx] == cdb_tag)) begin
                rd_value[slice_lo(k, WORD_SIZE) +: WORD_SIZE] = cdb_data;
                rd_status[slice_lo(k, FU_INDEX) +: FU_INDEX]  = READY_TAG;
            end
`endif
        end
    end

    // Popcount over the next-state tags keeps the counter exact under
    // simultaneous rename, broadcast and flush.
    always_comb begin
        w_pending_next = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (w_tag_next[r] != READY_TAG) begin
                w_pending_next = w_pending_next + (REG_INDEX + 1)'(1);
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_pending_count <= '0;
        end else begin
            r_pending_count <= w_pending_next;
        end
    end

    assign pending_count = r_pending_count;

endmodule

// File: tb/tb_reg_status_table.sv
// ----------------------------------------------------------------------------
// tb_reg_status_table
// Directed bench for reg_status_table with a behavioural model of the
// register file. The model applies the table's rules per register (broadcast,
// then renames in program order, then flush) and a compare process checks
// pending_count and every read port on each rising edge. Literal expectations
// in the directed sequence pin the model itself. Honours CDB_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_reg_status_table;

    localparam int RI    = 5;
    localparam int W     = 32;
    localparam int FI    = 3;
    localparam int NR    = 3;
    localparam int NI    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR*RI-1:0]  rd_num = '0;
    logic [NR*W-1:0]   rd_value;
    logic [NR*FI-1:0]  rd_status;
    logic [NI-1:0]     iss_en = '0;
    logic [NI*RI-1:0]  iss_reg = '0;
    logic [NI*FI-1:0]  iss_tag = '0;
    logic              cdb_valid = 1'b0;
    logic [FI-1:0]     cdb_tag = '0;
    logic [W-1:0]      cdb_data = '0;
    logic              flush = 1'b0;
    logic [RI:0]       pending_count;

    int checks   = 0;
    int failures = 0;

    reg_status_table dut (
        .clk           (clk),
        .reset         (reset),
        .rd_num        (rd_num),
        .rd_value      (rd_value),
        .rd_status     (rd_status),
        .iss_en        (iss_en),
        .iss_reg       (iss_reg),
        .iss_tag       (iss_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .flush         (flush),
        .pending_count (pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_val [DEPTH];
    logic [FI-1:0] m_tag [DEPTH];

    function automatic logic cdb_hits(input logic [FI-1:0] t);
        return cdb_valid && (cdb_tag != 0) && (t == cdb_tag);
    endfunction

    function automatic logic [FI-1:0] next_tag(input int r);
        logic [FI-1:0] t;
        t = m_tag[r];
        if (cdb_hits(m_tag[r])) t = 0;
        for (int p = 0; p < NI; p++)
            if (iss_en[p] && (int'(iss_reg[p*RI +: RI]) == r)) t = iss_tag[p*FI +: FI];
        if (flush) t = 0;
        return t;
    endfunction

    function automatic logic [W-1:0] next_val(input int r);
        return cdb_hits(m_tag[r]) ? cdb_data : m_val[r];
    endfunction

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_val[r] <= '0;
                m_tag[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                m_tag[r] <= next_tag(r);
                m_val[r] <= next_val(r);
            end
        end
    end

    // Compare process: outputs are stable at the rising edge (state moves on
    // the falling edge, stimulus moves just after the rising edge).
    always @(posedge clk) begin
        int            exp_pending;
        int            idx;
        logic [W-1:0]  ev;
        logic [FI-1:0] es;
        exp_pending = 0;
        for (int r = 0; r < DEPTH; r++)
            if (m_tag[r] != 0) exp_pending++;
        check("pending_count", 64'(pending_count), 64'(exp_pending));
        for (int k = 0; k < NR; k++) begin
            idx = int'(rd_num[k*RI +: RI]);
            ev  = m_val[idx];
            es  = m_tag[idx];
`ifdef CDB_BYPASS_EN
            if (cdb_hits(es)) begin
                ev = cdb_data;
                es = 0;
            end
`endif
            check($sformatf("rd_value[%0d]", k), 64'(rd_value[k*W +: W]), 64'(ev));
            check($sformatf("rd_status[%0d]", k), 64'(rd_status[k*FI +: FI]), 64'(es));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        iss_en    = '0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
        #1;
    endtask

    task automatic issue(input int p, input int r, input int t);
        iss_en[p]          = 1'b1;
        iss_reg[p*RI +: RI] = RI'(r);
        iss_tag[p*FI +: FI] = FI'(t);
    endtask

    task automatic cdb(input int t, input logic [W-1:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = FI'(t);
        cdb_data  = d;
    endtask

    task automatic rd_chk(input string nm, input int r, input logic [W-1:0] ev, input logic [FI-1:0] es);
        rd_num[RI-1:0] = RI'(r);
        #1;
        check({nm, "_value"}, 64'(rd_value[W-1:0]), 64'(ev));
        check({nm, "_status"}, 64'(rd_status[FI-1:0]), 64'(es));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rd_chk("reset_held", 5, 32'h0, 3'd0);
        reset = 1'b0;
        #1;

        // Every register reads zero/READY after reset.
        for (int r = 0; r < DEPTH; r++) rd_chk("reset_read", r, 32'h0, 3'd0);
        check("reset_pending", 64'(pending_count), 64'd0);

        // One tag held by two registers, cleared by one broadcast.
        issue(0, 5, 2);
        issue(1, 9, 2);
        tick(); idle();
        check("two_holders_pending", 64'(pending_count), 64'd2);
        rd_chk("r5_renamed", 5, 32'h0, 3'd2);
        rd_chk("r9_renamed", 9, 32'h0, 3'd2);
        cdb(2, 32'hDEADBEEF);
        tick(); idle();
        rd_chk("r5_written", 5, 32'hDEADBEEF, 3'd0);
        rd_chk("r9_written", 9, 32'hDEADBEEF, 3'd0);
        check("two_holders_cleared", 64'(pending_count), 64'd0);

        // Both ports rename r3: higher port wins.
        issue(0, 3, 1);
        issue(1, 3, 4);
        tick(); idle();
        rd_chk("r3_priority", 3, 32'h0, 3'd4);
        check("r3_pending", 64'(pending_count), 64'd1);

        // Same-edge broadcast and rename of r7.
        issue(0, 7, 3);
        tick(); idle();
        check("r7_pending", 64'(pending_count), 64'd2);
        cdb(3, 32'h55);
        issue(0, 7, 6);
        tick(); idle();
        rd_chk("r7_cdb_and_rename", 7, 32'h55, 3'd6);
        check("r7_still_pending", 64'(pending_count), 64'd2);

        // Flush with pending registers, a same-edge rename and a landing broadcast.
        issue(0, 1, 1);
        issue(1, 2, 2);
        tick(); idle();
        issue(0, 4, 5);
        tick(); idle();
        check("pre_flush_pending", 64'(pending_count), 64'd5);
        flush = 1'b1;
        issue(0, 8, 7);
        cdb(6, 32'hABC);
        tick(); idle();
        check("flush_pending", 64'(pending_count), 64'd0);
        rd_chk("flush_r8", 8, 32'h0, 3'd0);
        rd_chk("flush_r7_cdb_lands", 7, 32'hABC, 3'd0);
        rd_chk("flush_r5_value_kept", 5, 32'hDEADBEEF, 3'd0);
        rd_chk("flush_r4", 4, 32'h0, 3'd0);

        // Broadcast visibility before the edge.
        issue(0, 10, 5);
        tick(); idle();
        cdb(5, 32'h1234);
`ifdef CDB_BYPASS_EN
        rd_chk("bypass_r10", 10, 32'h1234, 3'd0);
`else
        rd_chk("no_bypass_r10", 10, 32'h0, 3'd5);
`endif
        tick(); idle();
        rd_chk("r10_after_edge", 10, 32'h1234, 3'd0);

        // Broadcast of the READY tag is ignored.
        issue(0, 11, 1);
        tick(); idle();
        cdb(0, 32'hFFFF);
        tick(); idle();
        rd_chk("ready_tag_ignored", 11, 32'h0, 3'd1);

        // Dense mixed traffic over a few registers; the model checks each cycle.
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < NI; p++) begin
                iss_en[p] = 1'($urandom_range(0, 1));
                iss_reg[p*RI +: RI] = RI'($urandom_range(0, 7));
                iss_tag[p*FI +: FI] = FI'($urandom_range(1, 7));
            end
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag   = FI'($urandom_range(0, 7));
            cdb_data  = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NR; k++) rd_num[k*RI +: RI] = RI'($urandom_range(0, 7));
            tick();
        end
        idle();

        // Asynchronous reset mid-operation, away from any clock edge.
        issue(0, 12, 3);
        tick(); idle();
        check("pre_reset_r12_pending", 64'(pending_count != 0), 64'd1);
        reset = 1'b1;
        #1;
        check("async_reset_pending", 64'(pending_count), 64'd0);
        rd_chk("async_reset_r12", 12, 32'h0, 3'd0);
        rd_chk("async_reset_r5", 5, 32'h0, 3'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Parametrised register status table for the Tomasulo core. It combines the architectural register values with a per-register producer tag (the FU index that will write the register) in one block. Each cycle it accepts up to NUM_ISSUE rename writes from the issue stage and one common-data-bus (CDB) broadcast that retires matching tags. It provides NUM_READ combinational operand lookups to the reservation stations, plus a synchronous flush and a pending-register counter.

## Interface
- REG_INDEX, default 5: register number width; table depth is 2**REG_INDEX.
- WORD_SIZE, default 32: register value width.
- FU_INDEX, default 3: producer tag width.
- READY, default 0: tag value meaning "value valid, no pending producer".
- NUM_READ, default 3: number of operand lookup ports.
- NUM_ISSUE, default 2: number of rename write ports; higher index is later in program order.
- clk  in  1  single clock; all state updates on falling edge.
- reset  in  1  asynchronous, active-high.
- rd_num  in  NUM_READ*REG_INDEX  packed lookup register numbers, port k at bits [k*REG_INDEX +: REG_INDEX].
- rd_value  out  NUM_READ*WORD_SIZE  value of each looked-up register.
- rd_status  out  NUM_READ*FU_INDEX  producer tag of each looked-up register.
- iss_en  in  NUM_ISSUE  rename write enables.
- iss_reg  in  NUM_ISSUE*REG_INDEX  destination registers.
- iss_tag  in  NUM_ISSUE*FU_INDEX  new producer tags; must not equal READY when enabled.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  FU_INDEX  broadcasting FU.
- cdb_data  in  WORD_SIZE  broadcast result.
- flush  in  1  synchronous clear of all tags to READY; values are kept.
- pending_count  out  REG_INDEX+1  number of registers whose tag is not READY.

## Operation
- Reset: every tag = READY, every value = 0, pending_count = 0. Reads are combinational, so rd_status = READY and rd_value = 0 while reset is held.
- Lookup: rd_value/rd_status follow stored state combinationally from rd_num. The bypass described under Configuration modifies this when enabled.
- CDB write: on a falling edge with cdb_valid, every register r with tag[r] == cdb_tag gets value[r] = cdb_data and tag[r] = READY. Registers with other tags are untouched. cdb_tag == READY is ignored.
- Rename write: on a falling edge, each enabled issue port sets tag[iss_reg] = iss_tag. Values are untouched.
- Same register, two issue ports: the highest-index port's tag wins.
- Same edge, CDB match and rename of the same register: the value takes cdb_data and the tag takes the new iss_tag. The rename wins on status.
- flush: on a falling edge, all tags become READY and values are unchanged. flush overrides same-edge renames, but a same-edge CDB value write still lands.
- pending_count: registered, updated on the same edge as the tags, and always equal to the popcount of non-READY tags after the edge. It must be computed from the next-state tags, not incremented.
- A tag may be held by several registers at once; one broadcast clears all of them.

## Timing
- Lookup latency is zero (combinational). State changes are visible to readers immediately after the falling edge. The issue stage samples on the following rising edge.
- A rename and a read of the same register in the same cycle: the read returns the old tag.
- reset asserted mid-operation clears state immediately, regardless of clk.
- Throughput: NUM_ISSUE renames plus one broadcast every cycle, with no stall.

## Configuration
- CDB_BYPASS_EN defined: when cdb_valid is high and a read port's stored tag equals cdb_tag (and is not READY), that port returns rd_value = cdb_data and rd_status = READY in the same cycle.
- CDB_BYPASS_EN undefined: reads show stored state only, so the consumer sees the result one edge later.

## Structure
- Shared package holds the REG_INDEX, WORD_SIZE, FU_INDEX and READY defaults, plus the packed-slice helper widths. Parameters default from it.
- Natural sub-module: reg_status_entry, one per register. It holds value and tag and computes next state from the broadcast, the per-entry rename select and flush.
- The top level holds the rename decode (priority by port index), the read muxes, the optional bypass and the popcount.

## Test plan
- Reset, then read r0..r31 -> all rd_status = 0 and rd_value = 0; pending_count = 0.
- Issue r5 <- tag 2 and r9 <- tag 2 on one edge, then CDB tag 2 with data 0xDEADBEEF -> both registers read 0xDEADBEEF with status 0; pending_count goes 2 then 0.
- Both issue ports rename r3 (tag 1 on port 0, tag 4 on port 1) -> r3 status = 4; pending_count = 1.
- r7 holds tag 3; on the same edge, CDB tag 3 with data 0x55 and a rename of r7 to tag 6 -> r7 value = 0x55, status = 6.
- flush with r1, r2, r4 pending plus a same-edge rename of r8 -> all tags 0, values unchanged, pending_count = 0.
- With CDB_BYPASS_EN, r10 at tag 5 and CDB tag 5 with data 0x1234 before the edge -> rd_value = 0x1234 and rd_status = 0 combinationally. Without CDB_BYPASS_EN, the read returns status 5 until the edge.
